// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/freeze sequencing for the five-stage pipeline; `PIPE_CTRL_FWD_EN selects load-use-only hazards
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  i_id_src1,
  input  logic [3:0]  i_id_src2,
  input  logic        i_id_uses_src1,
  input  logic        i_id_two_src,
  input  logic [3:0]  i_exe_dest,
  input  logic        i_exe_wb_en,
  input  logic        i_exe_mem_read,
  input  logic [3:0]  i_mem_dest,
  input  logic        i_mem_wb_en,
  input  logic        i_exe_branch,
  input  logic        i_mem_access,
  input  logic        i_sram_ready,
  output logic        o_stall_if,
  output logic        o_flush_ifid,
  output logic        o_flush_idex,
  output logic        o_freeze,
  output logic        o_sram_go,
  output logic        o_mem_timeout,
  output logic [31:0] o_stall_count
);
  typedef enum logic {S_IDLE, S_ACCESS} state_t;
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
  state_t      r_state, w_next;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic        r_tmo, w_tmo_set, w_frz, w_go;
  logic [31:0] r_sc;
  logic        w_raw_exe, w_raw_mem, w_hazard;
  assign w_raw_exe = i_exe_wb_en & ((i_id_uses_src1 & (i_id_src1 == i_exe_dest)) | (i_id_two_src & (i_id_src2 == i_exe_dest)));
  assign w_raw_mem = i_mem_wb_en & ((i_id_uses_src1 & (i_id_src1 == i_mem_dest)) | (i_id_two_src & (i_id_src2 == i_mem_dest)));
`ifdef PIPE_CTRL_FWD_EN
  assign w_hazard = w_raw_exe & i_exe_mem_read;
`else
  assign w_hazard = w_raw_exe | w_raw_mem;
`endif
  // memory FSM next state: freeze while an access is pending, release on ready or timeout
  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    w_tmo_set = 1'b0;
    w_frz     = 1'b0;
    w_go      = 1'b0;
    if (r_state == S_IDLE) begin
      w_frz     = i_mem_access;
      w_cnt_nxt = '0;
      w_next    = i_mem_access ? S_ACCESS : S_IDLE;
    end else begin
      w_go = 1'b1;
      if (i_sram_ready) begin
        w_next = S_IDLE;
      end else if (r_cnt == LAST) begin
        w_tmo_set = 1'b1;
        w_next    = S_IDLE;
      end else begin
        w_frz     = 1'b1;
        w_cnt_nxt = r_cnt + 8'd1;
      end
    end
  end
  assign o_freeze      = ~rst & w_frz;
  assign o_sram_go     = ~rst & w_go;
  assign o_stall_if    = ~rst & ~w_frz & ~i_exe_branch & w_hazard;
  assign o_flush_ifid  = ~rst & ~w_frz & i_exe_branch;
  assign o_flush_idex  = ~rst & ~w_frz & (i_exe_branch | w_hazard);
  assign o_mem_timeout = r_tmo;
  assign o_stall_count = r_sc;
  // state, timeout counter, sticky timeout flag and saturating stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_tmo   <= 1'b0;
      r_sc    <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      if (w_tmo_set) r_tmo <= 1'b1;
      if ((o_stall_if | o_freeze) && r_sc != '1) r_sc <= r_sc + 32'd1;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: randomized and directed scoreboard check of pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  localparam int TO = 4;
  logic clk = 0, rst = 1;
  logic [3:0] id_src1 = 0, id_src2 = 0, exe_dest = 0, mem_dest = 0;
  logic id_uses_src1 = 0, id_two_src = 0, exe_wb_en = 0, exe_mem_read = 0, mem_wb_en = 0;
  logic exe_branch = 0, mem_access = 0, sram_ready = 0;
  logic stall_if, flush_ifid, flush_idex, freeze, sram_go, mem_timeout;
  logic [31:0] stall_count;
  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_id_src1(id_src1), .i_id_src2(id_src2), .i_id_uses_src1(id_uses_src1), .i_id_two_src(id_two_src),
    .i_exe_dest(exe_dest), .i_exe_wb_en(exe_wb_en), .i_exe_mem_read(exe_mem_read),
    .i_mem_dest(mem_dest), .i_mem_wb_en(mem_wb_en), .i_exe_branch(exe_branch),
    .i_mem_access(mem_access), .i_sram_ready(sram_ready),
    .o_stall_if(stall_if), .o_flush_ifid(flush_ifid), .o_flush_idex(flush_idex),
    .o_freeze(freeze), .o_sram_go(sram_go), .o_mem_timeout(mem_timeout), .o_stall_count(stall_count)
  );

  typedef struct packed {logic st, fi, fd, fz, go, tmo; logic [31:0] sc;} exp_t;
  exp_t q[$];
  int n_vec = 0, n_err = 0;

  // reference: memory access tracked as "which access cycle is this" plus sticky flags
  bit m_busy = 0, m_tmo = 0;
  int m_k = 0;
  logic [31:0] m_sc = 0;

  task automatic step();
    exp_t e;
    bit re, rm, hz, fz;
    e = '0;
    e.tmo = m_tmo;
    e.sc = m_sc;
    if (rst) begin
      m_busy = 0; m_k = 0; m_tmo = 0; m_sc = 0;
    end else begin
      re = exe_wb_en && ((id_uses_src1 && id_src1 == exe_dest) || (id_two_src && id_src2 == exe_dest));
      rm = mem_wb_en && ((id_uses_src1 && id_src1 == mem_dest) || (id_two_src && id_src2 == mem_dest));
`ifdef PIPE_CTRL_FWD_EN
      hz = re && exe_mem_read;
`else
      hz = re || rm;
`endif
      e.go = m_busy;
      fz = 0;
      if (!m_busy) begin
        fz = mem_access;
        if (mem_access) begin m_busy = 1; m_k = 1; end
      end else if (sram_ready) m_busy = 0;
      else if (m_k == TO) begin m_busy = 0; m_tmo = 1; end
      else begin fz = 1; m_k++; end
      e.fz = fz;
      e.st = !fz && !exe_branch && hz;
      e.fi = !fz && exe_branch;
      e.fd = !fz && (exe_branch || hz);
      if ((e.st || fz) && m_sc != 32'hFFFF_FFFF) m_sc++;
    end
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    n_vec++;
    if (a !== x) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, x, $time);
    end
  endtask

  // monitor: every cycle the DUT presents a full output set, compared mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("stallIF", {31'd0, stall_if}, {31'd0, e.st});
      chk("flushIFID", {31'd0, flush_ifid}, {31'd0, e.fi});
      chk("flushIDEX", {31'd0, flush_idex}, {31'd0, e.fd});
      chk("freeze", {31'd0, freeze}, {31'd0, e.fz});
      chk("sramGo", {31'd0, sram_go}, {31'd0, e.go});
      chk("memTimeout", {31'd0, mem_timeout}, {31'd0, e.tmo});
      chk("stallCount", stall_count, e.sc);
    end
  end

  task automatic quiet();
    id_uses_src1 = 0; id_two_src = 0; exe_wb_en = 0; exe_mem_read = 0; mem_wb_en = 0;
    exe_branch = 0; mem_access = 0; sram_ready = 0;
    id_src1 = 0; id_src2 = 0; exe_dest = 0; mem_dest = 0;
  endtask

  initial begin
    @(posedge clk); #1;
    step(); rst = 0;
    step();
    exe_wb_en = 1; exe_dest = 3; id_src1 = 3; id_uses_src1 = 1;
    step(); quiet(); step();
    exe_wb_en = 1; exe_dest = 3; id_src1 = 3; id_uses_src1 = 1; exe_mem_read = 1;
    step(); quiet();
    mem_wb_en = 1; mem_dest = 5; id_src2 = 5; id_two_src = 1;
    step(); quiet();
    exe_branch = 1; exe_wb_en = 1; exe_dest = 2; id_src1 = 2; id_uses_src1 = 1;
    step(); quiet();
    sram_ready = 1; step(); quiet();
    mem_access = 1; exe_branch = 1;
    repeat (3) step();
    sram_ready = 1; step();
    quiet(); step();
    mem_access = 1;
    repeat (2) step();
    sram_ready = 1; step(); sram_ready = 0;
    mem_access = 1;
    repeat (7) step();
    quiet(); repeat (3) step();
    mem_access = 1; repeat (2) step();
    rst = 1; step(); rst = 0; quiet();
    repeat (2) step();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      id_src1 = 4'($urandom_range(0, 3)); id_src2 = 4'($urandom_range(0, 3));
      exe_dest = 4'($urandom_range(0, 3)); mem_dest = 4'($urandom_range(0, 3));
      id_uses_src1 = 1'($urandom); id_two_src = 1'($urandom);
      exe_wb_en = 1'($urandom); exe_mem_read = 1'($urandom); mem_wb_en = 1'($urandom);
      exe_branch = ($urandom_range(0, 3) == 0);
      mem_access = ($urandom_range(0, 2) == 0);
      sram_ready = ($urandom_range(0, 2) == 0);
      step();
    end
    rst = 0; quiet();
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
